// File: rtl/surfturf_cmd_framer_pkg.sv
// surfturf_cmd_framer_pkg: command word layout and frame phase encoding shared with the SURF-side decoder
package surfturf_cmd_framer_pkg;
  localparam int CMD_TRIG_W = 15;
  localparam int CMD_RUNCMD_W = 2;
  localparam int CMD_FW_MARK_W = 2;
  localparam int CMD_SEQ_W = 3;
  localparam int CMD_FW_DATA_W = 8;
  typedef enum logic [1:0] {PH_BYTE0, PH_BYTE1, PH_BYTE2, PH_CAPTURE} phase_e;
  typedef struct packed {
    logic [CMD_FW_DATA_W-1:0] fw_data;
    logic [CMD_SEQ_W-1:0] seq;
    logic fw_valid;
    logic [CMD_FW_MARK_W-1:0] fw_mark;
    logic [CMD_RUNCMD_W-1:0] runcmd;
    logic trig_valid;
    logic [CMD_TRIG_W-1:0] trig;
  } cmd_word_t;
endpackage

// File: rtl/surfturf_cmd_framer_if.sv
// surfturf_cmd_framer_if: runcmd, trig and fw AXI4-stream bundle (master = register core, slave = framer)
interface surfturf_cmd_framer_if
  import surfturf_cmd_framer_pkg::*;
#(
  parameter int RUNCMD_BITS = 2,
  parameter int TRIG_BITS = 15
);
  logic [RUNCMD_BITS-1:0] runcmd_tdata;
  logic runcmd_tvalid;
  logic runcmd_tready;
  logic [TRIG_BITS-1:0] trig_tdata;
  logic trig_tvalid;
  logic trig_tready;
  logic [CMD_FW_DATA_W-1:0] fw_tdata;
  logic fw_tvalid;
  logic fw_tready;
  modport master(
    output runcmd_tdata, runcmd_tvalid, trig_tdata, trig_tvalid, fw_tdata, fw_tvalid,
    input runcmd_tready, trig_tready, fw_tready
  );
  modport slave(
    input runcmd_tdata, runcmd_tvalid, trig_tdata, trig_tvalid, fw_tdata, fw_tvalid,
    output runcmd_tready, trig_tready, fw_tready
  );
endinterface

// File: rtl/surfturf_cmd_framer.sv
// surfturf_cmd_framer: packs runcmd/trig/fw streams into a 32-bit word per 4-cycle frame, shifted out MSB byte first
// sysclk_i/sysclk_rst_i: clock, async active-high reset; sync_i: realign frame; txen_i: enable capture
// axis: stream slave (treadys pulse on capture); fw_mark_i/fw_marked_o: mark bits and transmitted pulse
// cmd_dat_o: serialized byte; cmd_start_o: high on byte 0 of each frame
module surfturf_cmd_framer
  import surfturf_cmd_framer_pkg::*;
#(
  parameter int RUNCMD_BITS = 2,
  parameter int TRIG_BITS = 15,
  parameter DEBUG = "FALSE"
)(
  input  logic sysclk_i,
  input  logic sysclk_rst_i,
  input  logic sync_i,
  input  logic txen_i,
  surfturf_cmd_framer_if.slave axis,
  input  logic [CMD_FW_MARK_W-1:0] fw_mark_i,
  output logic fw_marked_o,
  output logic [7:0] cmd_dat_o,
  output logic cmd_start_o
);
  phase_e r_phase;
  logic [CMD_SEQ_W-1:0] r_seq;
  logic [31:0] r_shift;
  logic w_cap;
  logic w_take;
  logic [TRIG_BITS-1:0] w_trig;
  logic [RUNCMD_BITS-1:0] w_runcmd;
  cmd_word_t w_word;
  // sync_i forces a capture on its own cycle; gated by reset so nothing is consumed while held
  assign w_cap = !sysclk_rst_i && (r_phase == PH_CAPTURE || sync_i);
  assign w_take = w_cap && txen_i;
  assign w_trig = axis.trig_tvalid ? axis.trig_tdata : '0;
  assign w_runcmd = axis.runcmd_tvalid ? axis.runcmd_tdata : '0;
  assign w_word = '{
    fw_data: axis.fw_tvalid ? axis.fw_tdata : 8'h00,
    seq: CMD_SEQ_W'(r_seq + 1'b1),
    fw_valid: axis.fw_tvalid,
    fw_mark: fw_mark_i,
    runcmd: CMD_RUNCMD_W'(w_runcmd),
    trig_valid: axis.trig_tvalid,
    trig: CMD_TRIG_W'(w_trig)
  };
  always_ff @(posedge sysclk_i or posedge sysclk_rst_i)
    if (sysclk_rst_i) begin
      r_phase <= PH_BYTE0;
      r_seq <= '0;
      r_shift <= '0;
    end else begin
      r_phase <= w_cap ? PH_BYTE0 : phase_e'(r_phase + 2'd1);
      if (w_take) r_seq <= r_seq + 1'b1;
      r_shift <= w_cap ? (w_take ? w_word : 32'h0) : {r_shift[23:0], 8'h00};
    end
  assign cmd_dat_o = r_shift[31:24];
  assign cmd_start_o = r_phase == PH_BYTE0;
  assign axis.runcmd_tready = w_take;
  assign axis.trig_tready = w_take;
  assign axis.fw_tready = w_take;
  assign fw_marked_o = w_take && |fw_mark_i;
  if (DEBUG == "TRUE") begin : g_ila
    // probe register for attaching an ILA on the output byte and phase
    logic [9:0] r_ila_probe;
    always_ff @(posedge sysclk_i) r_ila_probe <= {r_phase, cmd_dat_o};
  end
endmodule

// File: tb/tb_surfturf_cmd_framer.sv
// tb_surfturf_cmd_framer: directed plus randomized check of the command framer against a frame-level model
module tb_surfturf_cmd_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sync = 1'b0;
  logic txen = 1'b0;
  logic [1:0] fw_mark = 2'b00;
  logic fw_marked;
  logic [7:0] dat;
  logic start;
  int n_chk = 0;
  int n_fail = 0;
  logic b_rst = 1'b1, b_sync = 1'b0, b_txen = 1'b0;
  logic b_rv = 1'b0, b_tv = 1'b0, b_fv = 1'b0;
  logic [1:0] b_rd = 2'b00, b_mark = 2'b00;
  logic [14:0] b_td = '0;
  logic [7:0] b_fd = '0;
  int m_phase = 0;
  int m_seq = 0;
  logic [31:0] m_word = '0;
  logic [7:0] o_dat;
  logic o_start, o_rrdy, o_trdy, o_frdy, o_marked;
  logic [7:0] a_dat [48];
  logic a_start [48];
  logic a_trdy [48];
  logic a_rrdy [48];
  logic a_frdy [48];
  logic a_marked [48];
  surfturf_cmd_framer_if #(.RUNCMD_BITS(2), .TRIG_BITS(15)) axis();
  surfturf_cmd_framer #(.RUNCMD_BITS(2), .TRIG_BITS(15), .DEBUG("FALSE")) dut (
    .sysclk_i(clk),
    .sysclk_rst_i(rst),
    .sync_i(sync),
    .txen_i(txen),
    .axis(axis),
    .fw_mark_i(fw_mark),
    .fw_marked_o(fw_marked),
    .cmd_dat_o(dat),
    .cmd_start_o(start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    logic cap, take;
    @(negedge clk);
    rst = b_rst;
    sync = b_sync;
    txen = b_txen;
    fw_mark = b_mark;
    axis.runcmd_tvalid = b_rv;
    axis.runcmd_tdata = b_rd;
    axis.trig_tvalid = b_tv;
    axis.trig_tdata = b_td;
    axis.fw_tvalid = b_fv;
    axis.fw_tdata = b_fd;
    #1;
    cap = !b_rst && (m_phase == 3 || b_sync);
    take = cap && b_txen;
    chk("dat", {24'h0, dat}, {24'h0, m_word[(3 - m_phase) * 8 +: 8]});
    chk("start", {31'h0, start}, {31'h0, m_phase == 0});
    chk("runcmd_tready", {31'h0, axis.runcmd_tready}, {31'h0, take});
    chk("trig_tready", {31'h0, axis.trig_tready}, {31'h0, take});
    chk("fw_tready", {31'h0, axis.fw_tready}, {31'h0, take});
    chk("fw_marked", {31'h0, fw_marked}, {31'h0, take && b_mark != 2'b00});
    o_dat = dat;
    o_start = start;
    o_rrdy = axis.runcmd_tready;
    o_trdy = axis.trig_tready;
    o_frdy = axis.fw_tready;
    o_marked = fw_marked;
    @(posedge clk);
    if (b_rst) begin
      m_phase = 0;
      m_seq = 0;
      m_word = '0;
    end else begin
      if (take) m_seq = (m_seq + 1) % 8;
      if (cap)
        m_word = take ? {b_fv ? b_fd : 8'h00, 3'(m_seq), b_fv, b_mark, b_rv ? b_rd : 2'b00, b_tv, b_tv ? b_td : 15'h0} : 32'h0;
      m_phase = cap ? 0 : (m_phase + 1) % 4;
    end
  endtask
  task automatic rnd();
    b_txen = $urandom_range(0, 9) != 0;
    b_sync = $urandom_range(0, 15) == 0;
    b_rv = 1'($urandom);
    b_rd = 2'($urandom);
    b_tv = 1'($urandom);
    b_td = 15'($urandom);
    b_fv = 1'($urandom);
    b_fd = 8'($urandom);
    b_mark = $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b00;
  endtask
  initial begin
    axis.runcmd_tvalid = 1'b0;
    axis.runcmd_tdata = '0;
    axis.trig_tvalid = 1'b0;
    axis.trig_tdata = '0;
    axis.fw_tvalid = 1'b0;
    axis.fw_tdata = '0;
    #1;
    chk("rst_dat", {24'h0, dat}, 32'h0);
    chk("rst_start", {31'h0, start}, 32'h1);
    chk("rst_fw_marked", {31'h0, fw_marked}, 32'h0);
    step();
    step();
    b_rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      b_txen = !(k >= 24 && k < 32);
      b_tv = k >= 8 && k < 12;
      b_td = 15'h1234;
      b_fv = k >= 16 && k < 20;
      b_fd = 8'hA5;
      b_mark = (k >= 16 && k < 20) ? 2'b10 : 2'b00;
      b_rv = k >= 24 && k < 36;
      b_rd = 2'b11;
      b_sync = k == 37;
      step();
      a_dat[k] = o_dat;
      a_start[k] = o_start;
      a_trdy[k] = o_trdy;
      a_rrdy[k] = o_rrdy;
      a_frdy[k] = o_frdy;
      a_marked[k] = o_marked;
    end
    chk("first_capture", {31'h0, a_trdy[3]}, 32'h1);
    chk("no_early_capture", {29'h0, a_trdy[0], a_trdy[1], a_trdy[2]}, 32'h0);
    chk("start_b0", {30'h0, a_start[4], a_start[5]}, 32'h2);
    chk("idle_seq1", {24'h0, a_dat[5]}, 32'h20);
    chk("idle_seq2", {24'h0, a_dat[9]}, 32'h40);
    chk("trig_b0", {24'h0, a_dat[12]}, 32'h00);
    chk("trig_b1", {24'h0, a_dat[13]}, 32'h60);
    chk("trig_b2", {24'h0, a_dat[14]}, 32'h92);
    chk("trig_b3", {24'h0, a_dat[15]}, 32'h34);
    chk("trig_tready_once", {28'h0, a_trdy[8], a_trdy[9], a_trdy[10], a_trdy[11]}, 32'h1);
    chk("fw_b0", {24'h0, a_dat[20]}, 32'hA5);
    chk("fw_b1", {24'h0, a_dat[21]}, 32'hB8);
    chk("fw_marked_cap", {30'h0, a_marked[19], a_frdy[19]}, 32'h3);
    chk("fw_marked_once", {29'h0, a_marked[16], a_marked[17], a_marked[18]}, 32'h0);
    chk("txen_off_rdy", {30'h0, a_rrdy[27], a_rrdy[31]}, 32'h0);
    chk("txen_off_frame", {a_dat[28], a_dat[29], a_dat[30], a_dat[31]}, 32'h0);
    chk("txen_off_next", {24'h0, a_dat[33]}, 32'h0);
    chk("runcmd_b1", {24'h0, a_dat[37]}, 32'hE3);
    chk("sync_start", {31'h0, a_start[38]}, 32'h1);
    chk("sync_capture", {31'h0, a_rrdy[37]}, 32'h1);
    chk("seq_wrap", {24'h0, a_dat[39]}, 32'h00);
    for (int i = 0; i < 1500; i++) begin
      rnd();
      step();
    end
    b_tv = 1'b1;
    b_fv = 1'b1;
    b_txen = 1'b1;
    b_sync = 1'b0;
    for (int i = 0; i < 8 && m_phase != 2; i++) step();
    chk("reach_phase2", m_phase, 2);
    #2;
    rst = 1'b1;
    b_rst = 1'b1;
    #1;
    chk("rst_mid_dat", {24'h0, dat}, 32'h0);
    chk("rst_mid_start", {31'h0, start}, 32'h1);
    chk("rst_mid_rdy", {30'h0, axis.fw_tready, axis.trig_tready}, 32'h0);
    m_phase = 0;
    m_seq = 0;
    m_word = '0;
    step();
    step();
    b_rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rnd();
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
